// File: rtl/sram_fifo_pkg.sv
// Shared sizes and types for the SRAM-backed stream FIFO.
package sram_fifo_pkg;

    localparam int DEPTH      = 32;  // words in the two-port macro
    localparam int AW         = 5;   // macro address width
    localparam int DW         = 12;  // macro data width
    localparam int SKID_DEPTH = 2;   // output buffer entries
    localparam int LW         = 6;   // width of level (0..34)

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [LW-1:0] level_t;

endpackage

// File: rtl/sram_fifo_skid.sv
// Two-entry output buffer. head is the registered oldest word; a push and a
// pop in the same cycle are both honoured. The controller never pushes when
// the buffer is full, because its issue rule reserves a slot per in-flight read.
module sram_fifo_skid
    import sram_fifo_pkg::*;
(
    input  logic        CK,
    input  logic        RST,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  data_t       din,
    output data_t       head,
    output logic [1:0]  count
);

    data_t      e0;
    data_t      e1;
    logic [1:0] cnt;
    logic       pop_ok;

    assign pop_ok = pop && (cnt != 2'd0);
    assign head   = e0;
    assign count  = cnt;

    // Shift/fill the two entries according to push and pop.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= din;
                    else             e1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Stream FIFO controller around a 32x12 two-port synchronous SRAM macro.
// Port A writes, port B reads with one cycle of latency; a 2-entry skid
// behind port B turns the macro read into a registered valid/ready output.
//
// Handshakes: a word moves on a rising CK edge when valid and ready are both
// high in the cycle before it; valid never depends on ready, and once valid
// is high the data holds until the transfer. flush cancels both handshakes.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic        CK,
    input  logic        RST,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  data_t       in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output data_t       out_data,
    output level_t      level,
    output addr_t       mem_a,
    output logic        mem_csa,
    output logic        mem_web,
    output data_t       mem_di,
    output addr_t       mem_b,
    output logic        mem_csb,
    output logic        mem_oe,
    input  data_t       mem_do
);

    addr_t      wr_ptr;
    addr_t      rd_ptr;
    level_t     mem_cnt;
    logic       pend;
    logic [1:0] skid_cnt;
    logic       wr_acc;
    logic       pop;
    logic       issue;

    assign in_ready  = !RST && (mem_cnt < level_t'(DEPTH));
    assign out_valid = (skid_cnt != 2'd0);
    assign wr_acc    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Issue a read only if the skid will have room for it when it lands:
    // words already buffered plus the one in flight, minus this cycle's pop.
    assign issue = !RST && !flush && (mem_cnt != '0) &&
                   (({1'b0, skid_cnt} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

    assign mem_csa = wr_acc;
    assign mem_web = !wr_acc;
    assign mem_a   = wr_ptr;
    assign mem_di  = wr_acc ? in_data : '0;
    assign mem_csb = issue;
    assign mem_b   = rd_ptr;
    assign mem_oe  = 1'b1;

    assign level = mem_cnt + level_t'(pend) + level_t'(skid_cnt);

    // Pointers, SRAM occupancy and the in-flight read flag.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            pend    <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + addr_t'(1);
            if (issue)  rd_ptr <= rd_ptr + addr_t'(1);
            case ({wr_acc, issue})
                2'b10:   mem_cnt <= mem_cnt + level_t'(1);
                2'b01:   mem_cnt <= mem_cnt - level_t'(1);
                default: ;
            endcase
            pend <= issue;
        end
    end

    // mem_do is valid exactly in the cycle after an issue; a flush drops it.
    sram_fifo_skid u_skid (
        .CK    (CK),
        .RST   (RST),
        .flush (flush),
        .push  (pend && !flush),
        .pop   (pop),
        .din   (mem_do),
        .head  (out_data),
        .count (skid_cnt)
    );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: behavioural SRAM with 1-cycle read latency, and a
// queue model of the stream contents. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. "Cycle c" is the
// interval between rising edges c-1 and c; a write seen in cycle 0 is taken
// at edge 0, the read goes to the macro at edge 1, the skid loads at edge 2,
// so out_valid is first seen in cycle 3.
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

    logic        CK = 1'b0;
    logic        RST;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    data_t       in_data;
    logic        out_valid;
    logic        out_ready;
    data_t       out_data;
    level_t      level;
    addr_t       mem_a;
    logic        mem_csa;
    logic        mem_web;
    data_t       mem_di;
    addr_t       mem_b;
    logic        mem_csb;
    logic        mem_oe;
    data_t       mem_do = '0;

    int n_cmp = 0;
    int n_bad = 0;

    sram_fifo_ctrl dut (
        .CK(CK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .mem_a(mem_a), .mem_csa(mem_csa), .mem_web(mem_web), .mem_di(mem_di),
        .mem_b(mem_b), .mem_csb(mem_csb), .mem_oe(mem_oe), .mem_do(mem_do)
    );

    // Clock and watchdog.
    always #5 CK = ~CK;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural macro: sampled at CK rise, read data appears one cycle later.
    data_t sram [DEPTH];
    always @(posedge CK) begin
        if (mem_csa && !mem_web) sram[mem_a] <= mem_di;
        if (mem_csb && mem_oe)   mem_do <= sram[mem_b];
    end

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic smp();
        @(negedge CK);
    endtask

    task automatic do_reset();
        RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) cyc();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [45:0] got;
        logic [45:0] exp;
        RST = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 12'hFFF; out_ready = 1'b1;
        repeat (2) cyc();
        smp();
        got = {in_ready, out_valid, out_data, level, mem_csa, mem_web, mem_csb,
               mem_oe, mem_a, mem_b, mem_di};
        exp = {1'b0, 1'b0, 12'h000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 12'h000};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_pins: got %h want %h", got, exp); end
        cyc();
        RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        smp();
        n_cmp++;
        if (in_ready !== 1'b1 || level !== 6'd0) begin
            n_bad++; $display("FAIL reset_release: in_ready %b level %0d want 1 and 0", in_ready, level);
        end
        cyc();
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 12'hABC;
        smp();
        n_cmp++;
        if (mem_csa !== 1'b1 || mem_web !== 1'b0 || mem_a !== 5'd0 || mem_di !== 12'hABC) begin
            n_bad++; $display("FAIL single_write_pins: csa %b web %b a %0d di %h want 1 0 0 abc",
                              mem_csa, mem_web, mem_a, mem_di);
        end
        cyc();
        in_valid = 1'b0;
        smp();
        n_cmp++;
        if (mem_csb !== 1'b1 || mem_b !== 5'd0) begin
            n_bad++; $display("FAIL single_issue: csb %b b %0d want 1 0", mem_csb, mem_b);
        end
        cyc();
        smp();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: out_valid %b want 0", out_valid); end
        cyc();
        smp();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 12'hABC || level !== 6'd1) begin
            n_bad++; $display("FAIL single_out: valid %b data %h level %0d want 1 abc 1",
                              out_valid, out_data, level);
        end
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        smp();
        n_cmp++;
        if (level !== 6'd0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_drain: level %0d valid %b want 0 0", level, out_valid);
        end
        cyc();
    endtask

    task automatic test_fill();
        int pops;
        do_reset();
        for (int i = 0; i < 34; i++) begin
            in_valid = 1'b1; in_data = 12'(i);
            smp();
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready: word %0d in_ready %b want 1", i, in_ready); end
            cyc();
        end
        in_data = 12'h7FF;
        repeat (3) begin
            smp();
            n_cmp++;
            if (in_ready !== 1'b0 || level !== 6'd34 || mem_csa !== 1'b0) begin
                n_bad++; $display("FAIL fill_full: in_ready %b level %0d csa %b want 0 34 0",
                                  in_ready, level, mem_csa);
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; pops = 0;
        for (int c = 0; c < 200 && pops < 34; c++) begin
            smp();
            if (out_valid) begin
                n_cmp++;
                if (out_data !== 12'(pops)) begin
                    n_bad++; $display("FAIL fill_order: got %h want %h", out_data, 12'(pops));
                end
                pops++;
            end
            cyc();
        end
        out_ready = 1'b0;
        smp();
        n_cmp++;
        if (pops != 34 || level !== 6'd0) begin
            n_bad++; $display("FAIL fill_drain: popped %0d level %0d want 34 0", pops, level);
        end
        cyc();
    endtask

    // Drives in_valid = out_ready = 1 and checks order, latency and gaps.
    task automatic run_stream(input string tag, input int cycles);
        data_t exp_q[$];
        int    first_out;
        int    gaps;
        bit    wrap_a;
        bit    wrap_b;
        addr_t prev_a;
        addr_t prev_b;
        first_out = -1; gaps = 0; wrap_a = 0; wrap_b = 0; prev_a = '0; prev_b = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            in_data = 12'($urandom_range(0, 4095));
            smp();
            n_cmp++;
            if (level !== 6'(exp_q.size())) begin
                n_bad++; $display("FAIL %s_level: cycle %0d got %0d want %0d", tag, c, level, exp_q.size());
            end
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    n_bad++; $display("FAIL %s_order: cycle %0d got %h", tag, c, out_data);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (first_out < 0) first_out = c;
            end else if (first_out >= 0) begin
                gaps++;
            end
            if (mem_csa && prev_a == 5'd31 && mem_a == 5'd0) wrap_a = 1;
            if (mem_csb && prev_b == 5'd31 && mem_b == 5'd0) wrap_b = 1;
            if (mem_csa) prev_a = mem_a;
            if (mem_csb) prev_b = mem_b;
            if (in_ready) exp_q.push_back(in_data);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (first_out != 3 || gaps != 0) begin
            n_bad++; $display("FAIL %s_flow: first output cycle %0d gaps %0d want 3 0", tag, first_out, gaps);
        end
        if (cycles > 40) begin
            n_cmp++;
            if (!wrap_a || !wrap_b) begin
                n_bad++; $display("FAIL %s_wrap: write wrap %0d read wrap %0d want 1 1", tag, wrap_a, wrap_b);
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        run_stream("stream", 100);
    endtask

    task automatic test_random();
        data_t exp_q[$];
        int    pin;
        int    pout;
        int    idle;
        do_reset();
        pin = 50; pout = 50; idle = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c % 1000 == 0) begin
                pin = $urandom_range(10, 95); pout = $urandom_range(10, 95);
            end
            in_valid  = ($urandom_range(0, 99) < pin);
            out_ready = ($urandom_range(0, 99) < pout);
            in_data   = 12'($urandom_range(0, 4095));
            smp();
            n_cmp++;
            if (level !== 6'(exp_q.size()) || level > 6'd34) begin
                n_bad++; $display("FAIL rand_level: cycle %0d got %0d want %0d", c, level, exp_q.size());
            end
            if (exp_q.size() < 32) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rand_ready: cycle %0d got 0 want 1", c); end
            end else if (exp_q.size() == 34) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rand_full: cycle %0d got 1 want 0", c); end
            end
            if (mem_csa && mem_csb) begin
                n_cmp++;
                if (mem_a === mem_b) begin n_bad++; $display("FAIL rand_collide: cycle %0d addr %0d both ports", c, mem_a); end
            end
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    n_bad++; $display("FAIL rand_order: cycle %0d got %h", c, out_data);
                end
            end
            idle = (exp_q.size() > 0 && !out_valid) ? idle + 1 : 0;
            if (idle == 3) begin
                n_cmp++; n_bad++; $display("FAIL rand_stall: cycle %0d data held but out_valid low", c);
            end
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(in_data);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1; in_data = 12'h100 + 12'(i);
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
        smp();
        n_cmp++;
        if (mem_csb !== 1'b1) begin n_bad++; $display("FAIL flush_setup: csb %b want 1", mem_csb); end
        cyc();
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 12'hEEE;
        smp();
        n_cmp++;
        if (level !== 6'd20 || mem_csa !== 1'b0 || mem_csb !== 1'b0) begin
            n_bad++; $display("FAIL flush_cycle: level %0d csa %b csb %b want 20 0 0", level, mem_csa, mem_csb);
        end
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) begin
            smp();
            n_cmp++;
            if (level !== 6'd0 || out_valid !== 1'b0) begin
                n_bad++; $display("FAIL flush_empty: level %0d valid %b want 0 0", level, out_valid);
            end
            cyc();
        end
        in_valid = 1'b1; in_data = 12'h5A5;
        cyc();
        in_valid = 1'b0;
        cyc();
        smp();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_early: valid %b want 0", out_valid); end
        cyc();
        smp();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 12'h5A5 || level !== 6'd1) begin
            n_bad++; $display("FAIL flush_refill: valid %b data %h level %0d want 1 5a5 1",
                              out_valid, out_data, level);
        end
        cyc();
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = 12'($urandom_range(0, 4095));
            cyc();
        end
        @(posedge CK);
        #3;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 12'h000 || level !== 6'd0 ||
            mem_csa !== 1'b0 || mem_web !== 1'b1 || mem_csb !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: rdy %b vld %b data %h lvl %0d csa %b web %b csb %b",
                              in_ready, out_valid, out_data, level, mem_csa, mem_web, mem_csb);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) cyc();
        RST = 1'b0;
        run_stream("after_rst", 20);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
